// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based forwarding, load-use stall, memory freeze and halt/drain control.
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS  = 5,
  parameter int PIPE_DEPTH  = 3,
  parameter int LOAD_AVAIL  = 2,
  parameter int STALL_CNT_W = 16,
  localparam int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [RF_ADDRESS-1:0]  id_rs1,
  input  logic [RF_ADDRESS-1:0]  id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [RF_ADDRESS-1:0]  id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   id_memacc,
  input  logic                   mem_ready,
  input  logic                   br_taken,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic                   pc_hold,
  output logic                   if_id_hold,
  output logic                   flush_if_id,
  output logic                   id_ex_bubble,
  output logic                   freeze,
  output logic [SEL_W-1:0]       fwd_a_sel,
  output logic [SEL_W-1:0]       fwd_b_sel,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t                   state_q, state_d;
  logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;
  logic [PIPE_DEPTH:1]      v_q, rw_q, mr_q, ma_q;
  logic [RF_ADDRESS-1:0]    rd_q [1:PIPE_DEPTH];
  logic [SEL_W-1:0]         sel_a, sel_b;
  logic                     lu_a, lu_b, frz, ld;
  // Scan oldest to youngest so the youngest matching stage is the last one written.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (id_use_rs1 && v_q[k] && rw_q[k] && rd_q[k] == id_rs1 && id_rs1 != '0) begin
        sel_a = SEL_W'(k);
        lu_a  = mr_q[k] && k < LOAD_AVAIL;
      end
      if (id_use_rs2 && v_q[k] && rw_q[k] && rd_q[k] == id_rs2 && id_rs2 != '0) begin
        sel_b = SEL_W'(k);
        lu_b  = mr_q[k] && k < LOAD_AVAIL;
      end
    end
  end
  assign frz       = v_q[LOAD_AVAIL] && ma_q[LOAD_AVAIL] && !mem_ready;
  assign freeze    = frz && !reset;
  assign fwd_a_sel = reset ? '0 : sel_a;
  assign fwd_b_sel = reset ? '0 : sel_b;
  assign halted    = !reset && state_q == HALTED;
  assign stall_cnt = cnt_q;
  assign ld        = id_valid && !id_ex_bubble && state_q == RUN;
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    flush_if_id  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (!reset) begin
      if (frz) begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (br_taken) begin
              flush_if_id  = 1'b1;
              id_ex_bubble = 1'b1;
            end else if (lu_a || lu_b) begin
              pc_hold      = 1'b1;
              if_id_hold   = 1'b1;
              id_ex_bubble = 1'b1;
              cnt_d        = &cnt_q ? cnt_q : cnt_q + 1'b1;
            end
            state_d = halt_req ? DRAIN : RUN;
          end
          DRAIN: begin
            pc_hold      = 1'b1;
            flush_if_id  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = |v_q ? DRAIN : HALTED;
          end
          default: begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = resume ? RUN : HALTED;
          end
        endcase
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      v_q     <= '0;
      rw_q    <= '0;
      mr_q    <= '0;
      ma_q    <= '0;
      for (int k = 1; k <= PIPE_DEPTH; k++) rd_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!frz) begin
        v_q     <= {v_q[PIPE_DEPTH-1:1], ld};
        rw_q    <= {rw_q[PIPE_DEPTH-1:1], id_regwrite};
        mr_q    <= {mr_q[PIPE_DEPTH-1:1], id_memread};
        ma_q    <= {ma_q[PIPE_DEPTH-1:1], id_memacc};
        rd_q[1] <= id_rd;
        for (int k = 2; k <= PIPE_DEPTH; k++) rd_q[k] <= rd_q[k-1];
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, load-use stall, freeze, branch flush, halt and reset.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_memacc;
  logic       mem_ready, br_taken, halt_req, resume;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       pc_hold, if_id_hold, flush_if_id, id_ex_bubble, freeze, halted;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;
  int total = 0;
  int fails = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memacc(id_memacc), .mem_ready(mem_ready), .br_taken(br_taken),
    .halt_req(halt_req), .resume(resume), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .flush_if_id(flush_if_id), .id_ex_bubble(id_ex_bubble), .freeze(freeze),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; id_memacc = 0; br_taken = 0; halt_req = 0; resume = 0;
  endtask

  task automatic ins(input logic [4:0] rd, input logic rw, input logic mr, input logic ma);
    id_valid = 1; id_rd = rd; id_regwrite = rw; id_memread = mr; id_memacc = ma;
  endtask

  task automatic src(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub);
    id_rs1 = a; id_rs2 = b; id_use_rs1 = ua; id_use_rs2 = ub;
  endtask

  initial begin
    clr();
    reset = 1; mem_ready = 1; br_taken = 1;
    #2;
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_flush", flush_if_id, 0);
    chk("rst_bubble", id_ex_bubble, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    tick();
    reset = 0; clr();
    // ALU forwarding from EX, MEM, WB
    ins(5, 1, 0, 0); tick();
    clr(); src(5, 0, 1, 0); #1;
    chk("fwd_ex", fwd_a_sel, 1);
    chk("fwd_ex_nohold", pc_hold, 0);
    tick();
    clr(); src(5, 5, 1, 1); #1;
    chk("fwd_mem_a", fwd_a_sel, 2);
    chk("fwd_mem_b", fwd_b_sel, 2);
    tick();
    clr(); src(5, 5, 1, 0); #1;
    chk("fwd_wb_a", fwd_a_sel, 3);
    chk("fwd_unused_b", fwd_b_sel, 0);
    tick();
    // load-use stall
    clr(); ins(6, 1, 1, 1); tick();
    clr(); ins(0, 0, 0, 0); src(6, 0, 1, 0); #1;
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_ifid_hold", if_id_hold, 1);
    chk("lu_bubble", id_ex_bubble, 1);
    chk("lu_fwd", fwd_a_sel, 1);
    chk("lu_cnt0", stall_cnt, 0);
    tick();
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_after_hold", pc_hold, 0);
    chk("lu_after_bubble", id_ex_bubble, 0);
    chk("lu_after_fwd", fwd_a_sel, 2);
    chk("lu_after_freeze", freeze, 0);
    tick();
    clr(); tick(); tick(); tick();
    // freeze on slow memory
    ins(8, 1, 1, 1); tick();
    clr(); mem_ready = 0; #1;
    chk("frz_pre", freeze, 0);
    tick();
    clr(); ins(9, 1, 0, 0); src(8, 0, 1, 0); br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_on", freeze, 1);
      chk("frz_pc_hold", pc_hold, 1);
      chk("frz_ifid_hold", if_id_hold, 1);
      chk("frz_flush", flush_if_id, 0);
      chk("frz_bubble", id_ex_bubble, 0);
      chk("frz_fwd", fwd_a_sel, 2);
      chk("frz_cnt", stall_cnt, 1);
      tick();
    end
    mem_ready = 1; br_taken = 0; #1;
    chk("frz_off", freeze, 0);
    chk("frz_off_fwd", fwd_a_sel, 2);
    chk("frz_off_hold", pc_hold, 0);
    tick();
    chk("frz_shift_fwd", fwd_a_sel, 3);
    clr(); tick(); tick(); tick();
    // branch overrides load-use; x0 never forwards
    ins(0, 1, 0, 0); tick();
    clr(); ins(10, 1, 1, 1); tick();
    clr(); ins(0, 0, 0, 0); src(10, 0, 1, 1); br_taken = 1; #1;
    chk("br_flush", flush_if_id, 1);
    chk("br_bubble", id_ex_bubble, 1);
    chk("br_pc_hold", pc_hold, 0);
    chk("br_ifid_hold", if_id_hold, 0);
    chk("br_fwd_a", fwd_a_sel, 1);
    chk("br_x0", fwd_b_sel, 0);
    tick();
    clr(); #1;
    chk("br_cnt", stall_cnt, 1);
    tick(); tick(); tick();
    // halt, drain, resume
    ins(1, 1, 0, 0); tick();
    ins(2, 1, 0, 0); tick();
    ins(3, 1, 0, 0); tick();
    clr(); halt_req = 1; #1;
    chk("halt_run_hold", pc_hold, 0);
    chk("halt_run_halted", halted, 0);
    tick();
    clr();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_pc_hold", pc_hold, 1);
      chk("drain_flush", flush_if_id, 1);
      chk("drain_bubble", id_ex_bubble, 1);
      chk("drain_halted", halted, 0);
      tick();
    end
    ins(4, 1, 0, 0); src(4, 0, 1, 0); #1;
    chk("halted", halted, 1);
    chk("halted_pc_hold", pc_hold, 1);
    chk("halted_ifid_hold", if_id_hold, 1);
    chk("halted_bubble", id_ex_bubble, 1);
    resume = 1;
    tick();
    resume = 0; #1;
    chk("resume_halted", halted, 0);
    chk("resume_pc_hold", pc_hold, 0);
    chk("resume_bubble", id_ex_bubble, 0);
    chk("resume_no_entry", fwd_a_sel, 0);
    tick();
    chk("resume_entry", fwd_a_sel, 1);
    // reset in the middle of drain
    clr(); ins(7, 1, 0, 0); tick();
    clr(); halt_req = 1; tick();
    clr(); #1;
    chk("mid_drain_flush", flush_if_id, 1);
    #2;
    reset = 1; src(7, 0, 1, 0); #1;
    chk("mrst_pc_hold", pc_hold, 0);
    chk("mrst_flush", flush_if_id, 0);
    chk("mrst_bubble", id_ex_bubble, 0);
    chk("mrst_halted", halted, 0);
    chk("mrst_cnt", stall_cnt, 0);
    chk("mrst_fwd", fwd_a_sel, 0);
    tick();
    reset = 0; #1;
    chk("post_rst_hold", pc_hold, 0);
    chk("post_rst_fwd", fwd_a_sel, 0);
    clr(); ins(7, 1, 0, 0); tick();
    clr(); src(7, 0, 1, 0); #1;
    chk("post_rst_run", fwd_a_sel, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RF_ADDRESS, default 5, register-specifier width.
REQ-002 SHALL have parameter PIPE_DEPTH, default 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); legal range 2..7.
REQ-003 SHALL have parameter LOAD_AVAIL, default 2, first stage index where load data is forwardable; legal range 2..PIPE_DEPTH.
REQ-004 SHALL have parameter STALL_CNT_W, default 16, stall counter width.
REQ-005 SHALL derive SEL_W = $clog2(PIPE_DEPTH+1).
REQ-006 Port: clk  in  1  clock; one clock, all state on rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-high reset.
REQ-008 Port: id_valid  in  1  ID holds a real instruction.
REQ-009 Port: id_rs1, id_rs2  in  RF_ADDRESS  ID source specifiers.
REQ-010 Port: id_use_rs1, id_use_rs2  in  1  ID instruction reads that source.
REQ-011 Port: id_rd  in  RF_ADDRESS  ID destination.
REQ-012 Port: id_regwrite, id_memread, id_memacc  in  1  ID writes RF / is load / touches data memory.
REQ-013 Port: mem_ready  in  1  data memory completes this cycle.
REQ-014 Port: br_taken  in  1  EX redirects PC.
REQ-015 Port: halt_req, resume  in  1  halt request / restart pulse.
REQ-016 Port: pc_hold, if_id_hold, flush_if_id, id_ex_bubble, freeze  out  1  pipeline controls.
REQ-017 Port: fwd_a_sel, fwd_b_sel  out  SEL_W  0=register file, k=stage k.
REQ-018 Port: halted  out  1  FSM in HALTED.
REQ-019 Port: stall_cnt  out  STALL_CNT_W  saturating count of load-use stall cycles.

Function
REQ-020 SHALL keep a PIPE_DEPTH-entry shift scoreboard {valid, rd, regwrite, memread, memacc}; entry 1 = EX.
REQ-021 Each non-frozen cycle SHALL shift entries up one; entry 1 loads the ID fields, or a bubble (valid=0) when id_valid=0, id_ex_bubble=1, or FSM not RUN.
REQ-022 freeze SHALL be 1 combinationally while entry LOAD_AVAIL valid and memacc and mem_ready=0; during freeze no entry or FSM state changes, and pc_hold=if_id_hold=1, flush_if_id=id_ex_bubble=0.
REQ-023 A source matches stage k when used, entry k valid and regwrite, rd equal, and rd!=0; lowest k (youngest) wins.
REQ-024 fwd_x_sel SHALL equal the winning k, else 0; x0 always selects 0.
REQ-025 Load-use hazard SHALL exist when a winning match is a memread entry with k < LOAD_AVAIL; then pc_hold=if_id_hold=id_ex_bubble=1.
REQ-026 br_taken (not frozen) SHALL assert flush_if_id=1 and id_ex_bubble=1, pc_hold=0; br_taken overrides load-use stall.
REQ-027 Priority SHALL be freeze > br_taken > load-use stall > normal.
REQ-028 stall_cnt SHALL increment once per load-use stall cycle (REQ-025 active, not overridden), saturating at all-ones.
REQ-029 FSM states RUN, DRAIN, HALTED; RUN->DRAIN when halt_req=1 and not frozen.
REQ-030 In DRAIN: pc_hold=1, flush_if_id=1, id_ex_bubble=1; DRAIN->HALTED when all entries invalid.
REQ-031 In HALTED: halted=1, pc_hold=if_id_hold=1, id_ex_bubble=1; HALTED->RUN on resume=1; halt_req ignored outside RUN.
REQ-032 br_taken during DRAIN SHALL still flush; stall_cnt SHALL not increment outside RUN.

Reset
REQ-033 reset=1 SHALL immediately clear all scoreboard entries, FSM to RUN, stall_cnt=0, from any state including mid-freeze or DRAIN.
REQ-034 During reset outputs SHALL be: fwd sels 0, freeze 0, halted 0, pc_hold 0, if_id_hold 0, flush_if_id 0, id_ex_bubble 0.

Verification
REQ-035 Issue ADD x5 then ID reads x5 next cycle -> fwd_a_sel=1; one cycle later with bubble in EX -> fwd_a_sel=2.
REQ-036 LW x6 then ID reads x6 -> one cycle pc_hold=id_ex_bubble=1, stall_cnt 0->1, then fwd sel=2.
REQ-037 Load in MEM with mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, scoreboard unchanged, stall_cnt unchanged.
REQ-038 br_taken with simultaneous load-use -> flush_if_id=1, pc_hold=0, stall_cnt unchanged; x0 sources -> sel 0.
REQ-039 halt_req with 3 valid entries -> DRAIN 3 cycles, halted=1, resume -> RUN; reset asserted mid-DRAIN -> RUN, stall_cnt=0.
